// File: rtl/stream_pack_pkg.sv
// Shared width helpers for the stream packing upsizer and its idle timer.
package stream_pack_pkg;

    localparam int unsigned DEF_IN_WIDTH       = 32;
    localparam int unsigned DEF_RATIO          = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    // Lane counter width; never narrower than one bit.
    function automatic int unsigned lane_idx_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int unsigned tmo_cnt_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

    function automatic int unsigned word_width(input int unsigned in_width,
                                               input int unsigned ratio);
        return in_width * ratio;
    endfunction

endpackage

// File: rtl/stream_pack_timeout.sv
// Idle timer: counts enabled cycles without a clear and saturates at TIMEOUT_CYCLES.
module stream_pack_timeout
    import stream_pack_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned TW = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i || !count_en_i) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/stream_pack_upsizer.sv
// Packs RATIO narrow beats into one wide word with a lane mask and packet-last flag.
// Optional idle flush of partial words under macro STREAM_PACK_TIMEOUT_EN.
module stream_pack_upsizer
    import stream_pack_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = DEF_IN_WIDTH,
    parameter int unsigned RATIO          = DEF_RATIO,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 s_valid_i,
    output logic                                 s_ready_o,
    input  logic [IN_WIDTH-1:0]                  s_data_i,
    input  logic                                 s_last_i,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i,
    output logic [word_width(IN_WIDTH, RATIO)-1:0] m_data_o,
    output logic [RATIO-1:0]                     m_mask_o,
    output logic                                 m_last_o
);

    localparam int unsigned WORD_W = word_width(IN_WIDTH, RATIO);
    localparam int unsigned CNT_W  = lane_idx_width(RATIO);
    localparam int unsigned ACC_W  = IN_WIDTH * (RATIO - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              m_valid_q, m_valid_d;
    logic [WORD_W-1:0] m_data_q, m_data_d;
    logic [RATIO-1:0]  m_mask_q, m_mask_d;
    logic              m_last_q, m_last_d;

    logic              accept, pop, complete, flush;
    logic [WORD_W-1:0] acc_full, word;
    logic [RATIO-1:0]  fill_mask;

    assign s_ready_o = !m_valid_q | m_ready_i;
    assign accept    = s_valid_i & s_ready_o;
    assign pop       = m_valid_q & m_ready_i;
    assign complete  = accept & ((cnt_q == CNT_W'(RATIO - 1)) | s_last_i);

`ifdef STREAM_PACK_TIMEOUT_EN
    logic tmo_expired;

    stream_pack_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_en_i(cnt_q != '0),
        .clear_i   (accept | flush),
        .expired_o (tmo_expired)
    );

    assign flush = tmo_expired & !s_valid_i & s_ready_o & (cnt_q != '0);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign flush = 1'b0;
`endif

    // One word builder serves both paths: a flush has no accept, so lane cnt stays empty.
    always_comb begin
        acc_full  = {{IN_WIDTH{1'b0}}, acc_q};
        word      = '0;
        fill_mask = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (i < 32'(cnt_q)) begin
                word[i*IN_WIDTH +: IN_WIDTH] = acc_full[i*IN_WIDTH +: IN_WIDTH];
                fill_mask[i] = 1'b1;
            end else if ((i == 32'(cnt_q)) && accept) begin
                word[i*IN_WIDTH +: IN_WIDTH] = s_data_i;
                fill_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_mask_d  = m_mask_q;
        m_last_d  = m_last_q;

        for (int unsigned i = 0; i < RATIO - 1; i++) begin
            if (accept && !complete && (i == 32'(cnt_q))) begin
                acc_d[i*IN_WIDTH +: IN_WIDTH] = s_data_i;
            end
        end

        if (complete || flush) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (complete) begin
            m_valid_d = 1'b1;
            m_data_d  = word;
            m_mask_d  = fill_mask;
            m_last_d  = s_last_i;
        end else if (flush) begin
            m_valid_d = 1'b1;
            m_data_d  = word;
            m_mask_d  = fill_mask;
            m_last_d  = 1'b0;
        end else if (pop) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_mask_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_mask_q  <= m_mask_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_mask_o  = m_mask_q;
    assign m_last_o  = m_last_q;

endmodule

// File: tb/tb_stream_pack_upsizer.sv
// Directed bench for stream_pack_upsizer (IN_WIDTH=32, RATIO=4, TIMEOUT_CYCLES=3).
module tb_stream_pack_upsizer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         s_last = 1'b0;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [127:0] m_data;
    logic [3:0]   m_mask;
    logic         m_last;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    stream_pack_upsizer #(
        .IN_WIDTH(32),
        .RATIO(4),
        .TIMEOUT_CYCLES(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .s_data_i (s_data),
        .s_last_i (s_last),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready),
        .m_data_o (m_data),
        .m_mask_o (m_mask),
        .m_last_o (m_last)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [127:0] d,
                             input logic [3:0] k, input logic l);
        check_eq({tag, " valid"}, 128'(m_valid), 128'(v));
        check_eq({tag, " data"},  m_data, d);
        check_eq({tag, " mask"},  128'(m_mask), 128'(k));
        check_eq({tag, " last"},  128'(m_last), 128'(l));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n_words;
        int unsigned n_low;

        #2 rst_n = 1'b0;
        #1;
        check_out("reset", 1'b0, '0, 4'h0, 1'b0);
        check_eq("reset s_ready", 128'(s_ready), 128'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Full word, back-to-back beats
        beat(32'h11, 1'b0); check_eq("t1 v1", 128'(m_valid), 128'd0);
        beat(32'h22, 1'b0); check_eq("t1 v2", 128'(m_valid), 128'd0);
        beat(32'h33, 1'b0); check_eq("t1 v3", 128'(m_valid), 128'd0);
        beat(32'h44, 1'b0);
        check_out("t1", 1'b1, 128'h00000044_00000033_00000022_00000011, 4'b1111, 1'b0);
        step();
        check_eq("t1 pop", 128'(m_valid), 128'd0);

        // Short packet closed by last
        beat(32'hA, 1'b0);
        beat(32'hB, 1'b1);
        check_out("t2", 1'b1, 128'h00000000_00000000_0000000B_0000000A, 4'b0011, 1'b1);
        check_eq("t2 upper lanes", 128'(m_data[127:64]), 128'd0);
        step();
        check_eq("t2 pop", 128'(m_valid), 128'd0);

        // Backpressure: stalled word holds; stalled last beat is not taken
        m_ready = 1'b0;
        beat(32'h1, 1'b0);
        beat(32'h2, 1'b0);
        beat(32'h3, 1'b0);
        beat(32'h4, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'h77;
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("t3 s_ready stall", 128'(s_ready), 128'd0);
            check_out("t3 stall", 1'b1, 128'h00000004_00000003_00000002_00000001, 4'b1111, 1'b0);
            step();
        end
        m_ready = 1'b1;
        #1;
        check_eq("t3 s_ready release", 128'(s_ready), 128'd1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_out("t3 replace", 1'b1, 128'h00000000_00000000_00000000_00000077, 4'b0001, 1'b1);
        step();
        check_eq("t3 pop", 128'(m_valid), 128'd0);

        // Continuous streaming of 8 beats
        n_words = 0;
        n_low   = 0;
        for (int i = 0; i < 8; i++) begin
            if (!s_ready) n_low++;
            beat(32'h100 + 32'(i), 1'b0);
            if (m_valid) n_words++;
            if (i == 3)
                check_out("t4 w0", 1'b1, 128'h00000103_00000102_00000101_00000100, 4'b1111, 1'b0);
            if (i == 7)
                check_out("t4 w1", 1'b1, 128'h00000107_00000106_00000105_00000104, 4'b1111, 1'b0);
        end
        check_eq("t4 words", 128'(n_words), 128'd2);
        check_eq("t4 ready low count", 128'(n_low), 128'd0);
        beat(32'hE1, 1'b1);
        check_out("t4 single0", 1'b1, 128'h000000E1, 4'b0001, 1'b1);
        check_eq("t4 s_ready replace", 128'(s_ready), 128'd1);
        beat(32'hE2, 1'b1);
        check_out("t4 single1", 1'b1, 128'h000000E2, 4'b0001, 1'b1);
        step();
        check_eq("t4 pop", 128'(m_valid), 128'd0);

        // Partial word left idle
        beat(32'h5, 1'b0);
`ifdef STREAM_PACK_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t5 idle valid", 128'(m_valid), 128'd0);
        end
        step();
        check_out("t5 flush", 1'b1, 128'h00000005, 4'b0001, 1'b0);
        step();
        check_eq("t5 pop", 128'(m_valid), 128'd0);
`else
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("t5 idle valid", 128'(m_valid), 128'd0);
        end
        beat(32'h6, 1'b0);
        beat(32'h7, 1'b0);
        beat(32'h8, 1'b0);
        check_out("t5 held", 1'b1, 128'h00000008_00000007_00000006_00000005, 4'b1111, 1'b0);
        step();
        check_eq("t5 pop", 128'(m_valid), 128'd0);
`endif

        // Reset mid-packet
        beat(32'hC1, 1'b0);
        beat(32'hC2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_out("t6 rst", 1'b0, '0, 4'h0, 1'b0);
        check_eq("t6 rst s_ready", 128'(s_ready), 128'd1);
        step();
        rst_n = 1'b1;
        step();
        beat(32'hD1, 1'b0);
        beat(32'hD2, 1'b0);
        beat(32'hD3, 1'b0);
        check_eq("t6 partial valid", 128'(m_valid), 128'd0);
        beat(32'hD4, 1'b0);
        check_out("t6 clean", 1'b1, 128'h000000D4_000000D3_000000D2_000000D1, 4'b1111, 1'b0);
        step();
        check_eq("t6 pop", 128'(m_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_pack_upsizer.md
STREAM_PACK_UPSIZER -- requirements
Module: stream_pack_upsizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: width in bits of one input beat.
REQ-002 SHALL have parameter RATIO, default 4 (>= 2): number of input beats packed into one output word.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16 (>= 1): idle cycles before a partial word is flushed; used only when STREAM_PACK_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port s_valid_i, input, 1 bit: input beat valid.
REQ-007 SHALL have port s_ready_o, output, 1 bit: input beat accepted when s_valid_i is also high.
REQ-008 SHALL have port s_data_i, input, IN_WIDTH bits: input beat payload.
REQ-009 SHALL have port s_last_i, input, 1 bit: marks the final beat of a packet.
REQ-010 SHALL have port m_valid_o, output, 1 bit: packed word valid.
REQ-011 SHALL have port m_ready_i, input, 1 bit: downstream accepts the word when m_valid_o is also high.
REQ-012 SHALL have port m_data_o, output, IN_WIDTH*RATIO bits: packed payload.
REQ-013 SHALL have port m_mask_o, output, RATIO bits: one bit per lane, set when that lane holds a beat.
REQ-014 SHALL have port m_last_o, output, 1 bit: the word closes a packet.

Function
REQ-015 SHALL define handshakes: accept = s_valid_i & s_ready_o; pop = m_valid_o & m_ready_i.
REQ-016 SHALL hold a lane counter cnt (0..RATIO-1) plus an accumulator of RATIO-1 lanes.
REQ-017 SHALL write accepted beat k (k = cnt) into lane k, bits [k*IN_WIDTH +: IN_WIDTH]; lane 0 is the first beat.
REQ-018 SHALL treat an accepted beat as completing when cnt == RATIO-1 or s_last_i is high.
REQ-019 On a completing beat, SHALL load the accumulator plus the current beat into the output register in the same edge, with m_last_o = s_last_i; cnt returns to 0.
REQ-020 In the packed word, SHALL drive every unfilled lane's data to zero and clear its mask bit.
REQ-021 SHALL drive s_ready_o = !m_valid_o | m_ready_i, independent of s_valid_i and s_last_i.
REQ-022 SHALL give a latency of 1 cycle: m_valid_o rises on the edge after the completing accept.
REQ-023 Throughput SHALL be 1 beat per cycle while m_ready_i stays high.
REQ-024 SHALL keep m_data_o, m_mask_o and m_last_o stable while m_valid_o is high and m_ready_i is low.
REQ-025 On a simultaneous pop and completing accept, SHALL replace the word, and m_valid_o stays high.
REQ-026 On a pop with no completing accept, SHALL clear m_valid_o.
REQ-027 SHALL ignore s_last_i on a non-accepted cycle.

Reset
REQ-028 On rst_n low, SHALL immediately force m_valid_o = 0, m_data_o = 0, m_mask_o = 0, m_last_o = 0, cnt = 0 and the timeout counter to 0.
REQ-029 On reset mid-packet, SHALL discard any partially packed or unpopped data.
REQ-030 After reset, s_ready_o SHALL be 1.

Configuration
REQ-031 With macro STREAM_PACK_TIMEOUT_EN defined, SHALL count consecutive cycles with cnt > 0 and no accept, saturating at TIMEOUT_CYCLES.
REQ-032 With STREAM_PACK_TIMEOUT_EN, when the count equals TIMEOUT_CYCLES, s_valid_i is low and (!m_valid_o | m_ready_i), SHALL flush the partial word with m_last_o = 0 and mask = lanes filled, then set cnt = 0.
REQ-033 With STREAM_PACK_TIMEOUT_EN, if s_valid_i is high on the timeout cycle, SHALL accept the beat normally; the flush does not occur and the counter clears.
REQ-034 Without STREAM_PACK_TIMEOUT_EN, SHALL hold partial words indefinitely until RATIO beats or s_last_i, and SHALL instantiate no timeout logic.

Structure
REQ-035 SHALL place shared constants in package stream_pack_pkg: lane-index width $clog2(RATIO), timeout-counter width $clog2(TIMEOUT_CYCLES+1), and helper function for word width IN_WIDTH*RATIO.
REQ-036 SHALL place the idle timer in one sub-module, stream_pack_timeout, instantiated only under STREAM_PACK_TIMEOUT_EN.

Verification
REQ-037 Bench SHALL drive RATIO=4 beats 0x11,0x22,0x33,0x44 back-to-back with m_ready_i=1, and check m_data_o = 0x00000044_00000033_00000022_00000011, mask 4'b1111, last 0, one cycle after beat 4.
REQ-038 Bench SHALL drive beats 0xA,0xB with s_last_i on 0xB, and check mask 4'b0011, last 1, lanes 2-3 zero.
REQ-039 Bench SHALL complete a word while m_ready_i=0 for 5 cycles, and check s_ready_o=0 and the output stable for those cycles, then the pop and s_ready_o=1 on the next cycle.
REQ-040 Bench SHALL stream 8 beats continuously with m_ready_i=1, and check 2 words produced, s_ready_o never low, and pop/replace in the same cycle.
REQ-041 With STREAM_PACK_TIMEOUT_EN and TIMEOUT_CYCLES=3, bench SHALL drive one beat 0x5 then idle, and check a flush with mask 4'b0001, last 0, exactly 3 idle cycles later; without the macro, no output.
REQ-042 Bench SHALL assert rst_n low after 2 of 4 beats, and check outputs zero at once and that the next 4 beats form a clean word with mask 4'b1111.
